// File: rtl/op_inverse_search_pkg.sv
// op_inverse_search_pkg: shared state enum, widths and the forward operation f(x,y)
package op_inverse_search_pkg;
    localparam int op_w   = 2;
    localparam int res_w  = 5;
    localparam int n_cand = 16;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    // Diagonal is x**y with 0**0 = 1; off-diagonal is a plain product.
    function automatic logic [res_w-1:0] f_op(input logic [op_w-1:0] x, input logic [op_w-1:0] y);
        logic [res_w-1:0] d;
        d = (x == 2'd2) ? 5'd4 : (x == 2'd3) ? 5'd27 : 5'd1;
        return (x == y) ? d : res_w'(x) * res_w'(y);
    endfunction
endpackage

// File: rtl/op_forward.sv
// op_forward: combinational forward operation on one candidate pair
module op_forward
    import op_inverse_search_pkg::*;
(
    input  logic [op_w-1:0]  x,
    input  logic [op_w-1:0]  y,
    output logic [res_w-1:0] f
);
    assign f = f_op(x, y);
endmodule

// File: rtl/op_inverse_search.sv
// op_inverse_search: exhaustively finds all (x,y) whose forward result equals target
module op_inverse_search
    import op_inverse_search_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [res_w-1:0] target,
    output logic             busy,
    output logic             match_valid,
    output logic [op_w-1:0]  match_x,
    output logic [op_w-1:0]  match_y,
    output logic             done,
    output logic [res_w-1:0] match_count
);
    state_t           state;
    logic [3:0]       cnt;
    logic [res_w-1:0] tgt;
    logic [res_w-1:0] fval;
    logic             hit;

    op_forward u_fwd (.x(cnt[3:2]), .y(cnt[1:0]), .f(fval));

    assign hit = (fval == tgt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            tgt         <= '0;
            busy        <= 1'b0;
            match_valid <= 1'b0;
            match_x     <= '0;
            match_y     <= '0;
            done        <= 1'b0;
            match_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    match_valid <= 1'b0;
                    done        <= 1'b0;
                    if (start) begin
                        tgt         <= target;
                        cnt         <= '0;
                        match_count <= '0;
                        busy        <= 1'b1;
                        state       <= SEARCH;
                    end
                end
                SEARCH: begin
                    match_valid <= hit;
                    if (hit) begin
                        match_x     <= cnt[3:2];
                        match_y     <= cnt[1:0];
                        match_count <= match_count + 5'd1;
                    end
                    cnt <= cnt + 4'd1;
                    // The last candidate ends the pass; the wrap of cnt is never evaluated.
                    if (cnt == 4'(n_cand - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    match_valid <= 1'b0;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_op_inverse_search.sv
// tb_op_inverse_search: cycle-level model comparison plus directed scenarios with literal results
module tb_op_inverse_search;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] target = '0;
    logic       busy, match_valid, done;
    logic [1:0] match_x, match_y;
    logic [4:0] match_count;

    op_inverse_search dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target(target),
        .busy(busy), .match_valid(match_valid), .match_x(match_x),
        .match_y(match_y), .done(done), .match_count(match_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = -1;
    int done_total = 0;
    int acc_cyc = 0;
    int obs[$];

    // model: ph 0 idle, 1..16 next candidate is ph-1, 17 done cycle
    int ph = 0, tt = 0, mc = 0, mx = 0, my = 0, mv = 0, dn = 0;
    int c, x, y, v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            ph = 0; tt = 0; mc = 0; mx = 0; my = 0; mv = 0; dn = 0;
        end else if (ph == 0) begin
            mv = 0; dn = 0;
            if (start) begin
                tt = target; mc = 0; ph = 1; acc_cyc = cyc;
            end
        end else if (ph == 17) begin
            mv = 0; dn = 0; ph = 0;
        end else begin
            c = ph - 1;
            x = c / 4;
            y = c % 4;
            v = (x == y) ? x ** y : x * y;
            mv = (v == tt) ? 1 : 0;
            if (mv == 1) begin
                mx = x; my = y; mc++;
            end
            dn = (ph == 16) ? 1 : 0;
            ph++;
        end
        #1;
        chk("busy", busy, (ph != 0) ? 1 : 0);
        chk("match_valid", match_valid, mv);
        chk("match_x", match_x, mx);
        chk("match_y", match_y, my);
        chk("done", done, dn);
        chk("match_count", match_count, mc);
        if (match_valid === 1'b1) obs.push_back(int'(match_x) * 4 + int'(match_y));
        if (done === 1'b1) begin
            done_cyc = cyc;
            done_total++;
        end
    end

    task automatic run(input logic [4:0] t, input logic [15:0] emask, input int en);
        int k;
        obs.delete();
        done_cyc = -1;
        @(negedge clk);
        target = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        target = ~t;
        for (int i = 0; i < 40 && done_cyc < 0; i++) @(negedge clk);
        chk("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
        chk("latency", done_cyc - acc_cyc, 16);
        chk("count_lit", match_count, en);
        chk("n_matches", obs.size(), en);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (emask[i]) begin
                chk("match_order", (k < obs.size()) ? obs[k] : -1, i);
                k++;
            end
        end
        @(negedge clk);
        @(negedge clk);
        chk("count_hold", match_count, en);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_count", match_count, 0);
        chk("rst_xy", {match_x, match_y}, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_no_start", busy, 0);

        run(5'd4,  16'h0400, 1);
        run(5'd0,  16'h111E, 6);
        run(5'd1,  16'h0021, 2);
        run(5'd27, 16'h8000, 1);
        run(5'd9,  16'h0000, 0);
        run(5'd6,  16'h4800, 2);
        run(5'd2,  16'h0240, 2);
        run(5'd3,  16'h2080, 2);
        run(5'd30, 16'h0000, 0);

        // start held high: one search per IDLE visit
        done_total = 0;
        @(negedge clk);
        target = 5'd4;
        start = 1'b1;
        repeat (54) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_start_dones", done_total, 3);

        // reset at E8 of a target=0 search
        done_cyc = -1;
        @(negedge clk);
        target = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_count", match_count, 0);
        chk("abort_valid", match_valid, 0);
        chk("abort_xy", {match_x, match_y}, 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cyc, -1);
        run(5'd6, 16'h4800, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
